font_port_arbiter: RTL and testbench
====================================

Name: font_port_arbiter

Overview:
- Shares the single-port, synchronous-read font ROM between two requesters.
  - Display side: the text renderer fetches one glyph row per request.
  - Host side: a loader or debug port reads and writes font bytes.
- The display has priority. A starvation counter guarantees the host a slot after a bounded wait.
- Sits between the text-console pixel pipeline and the font ROM instance. It drives the ROM's addr, write_en and din, and consumes its registered dout.

Parameters:
- CHAR_BITS, 7: glyph index width (128 glyphs).
- ROW_BITS, 4: glyph row index width (16 rows per glyph).
- ADDR_W, CHAR_BITS+ROW_BITS (11): ROM address width.
- DATA_W, 8: ROM data width (one glyph row, MSB = leftmost pixel).
- MAX_WAIT, 15: consecutive cycles a host request may stall before it is forced through. Range 1..255.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- disp_req  in  1  display fetch request; single cycle, no back-pressure.
- disp_char  in  CHAR_BITS  glyph code.
- disp_row  in  ROW_BITS  row within glyph.
- disp_valid  out  1  disp_data valid, one-cycle pulse.
- disp_data  out  DATA_W  glyph row bits.
- disp_miss  out  1  pulse: a disp_req was dropped because the host was forced.
- host_valid  in  1  host request pending.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  ROM address.
- host_wdata  in  DATA_W  write data.
- host_ready  out  1  request accepted this cycle (valid and ready both high = transfer).
- host_rvalid  out  1  read data valid, one-cycle pulse.
- host_rdata  out  DATA_W  read data.
- rom_addr  out  ADDR_W  to ROM addr.
- rom_we  out  1  to ROM write_en.
- rom_din  out  DATA_W  to ROM din.
- rom_dout  in  DATA_W  from ROM dout, registered, 1-cycle latency.

Behaviour:
- Reset values: all outputs 0, including rom_addr, rom_we, rom_din, disp_*, host_ready and host_rvalid. wait_cnt = 0. Tag pipeline cleared.
- Arbitration is evaluated each cycle (stage A):
  - forced = host_valid && (wait_cnt == MAX_WAIT).
  - Grant HOST if forced, or if host_valid && !disp_req.
  - Otherwise grant DISP if disp_req. Otherwise IDLE.
- host_ready is combinational: host_ready = host_valid && grant==HOST. It is never asserted while rst is high.
- wait_cnt:
  - Reset to 0 on a host grant or when !host_valid.
  - Otherwise increments while host_valid is stalled, saturating at MAX_WAIT.
- Stage A to stage B register: rom_addr, rom_we, rom_din and tag (NONE/DISP/HRD) are registered at the end of the grant cycle.
  - DISP grant: rom_addr = {disp_char, disp_row}, rom_we = 0.
  - Host write: rom_addr = host_addr, rom_din = host_wdata, rom_we = 1, tag = NONE.
  - Host read: rom_we = 0, tag = HRD.
  - IDLE: rom_we = 0, rom_addr holds its previous value, tag = NONE.
- Stage C: the ROM returns dout one cycle after rom_addr. The tag is delayed one more cycle and steers rom_dout.
  - tag DISP: disp_valid = 1, disp_data = rom_dout.
  - tag HRD: host_rvalid = 1, host_rdata = rom_dout.
  - Data outputs hold their last value when not valid.
- Latency: request accepted at cycle N gives data valid at N+2 for both display and host reads. Throughput is one access per cycle.
- Write cycles produce no return pulse. A read of an address in the cycle after a write to it returns the new data.
- disp_miss pulses at N+2 for a disp_req dropped at N. Its timing matches the missed disp_valid slot, so the renderer substitutes blank pixels.
- The host must hold host_valid, host_we, host_addr and host_wdata stable until host_ready. Deasserting early is allowed; wait_cnt then clears.
- Reset mid-operation: in-flight tags are cleared, so no disp_valid or host_rvalid pulse follows reset. A host write registered but not yet at the ROM is discarded (rom_we forced 0).

Test Plan:
- Display only: disp_req with char 0x41, row 3 at cycle 10 → rom_addr = 0x413 at 11; disp_valid with disp_data = mem[0x413] at 12. Back-to-back requests give 1/cycle throughput.
- Host write then read: write 0x5A5 ← 0xC3 with no display traffic → host_ready same cycle, rom_we = 1 for one cycle. A following read of 0x5A5 → host_rvalid 2 cycles after accept, host_rdata = 0xC3.
- Contention: disp_req and host_valid both high continuously, MAX_WAIT = 15:
  - host_ready rises on the 16th cycle.
  - disp_miss pulses exactly once, 2 cycles later.
  - All other disp_req cycles return disp_valid.
- Idle contention gap: disp_req low for one cycle while a host write is pending → host accepted in that gap, wait_cnt back to 0, no disp_miss.
- Reset mid-flight: assert rst the cycle after a display grant and a host read grant → no disp_valid or host_rvalid. All outputs 0 on the cycle after rst. A write pending at reset does not alter the ROM (read back the old value).
- Host abandons a request: host_valid high 5 cycles under display load, then low → host_ready never asserted, wait_cnt = 0, display stream unaffected.

Source files
------------

// File: rtl/font_port_arbiter_if.sv
// rtl/font_port_arbiter_if.sv - display, host and font ROM signal bundle for the font port arbiter
interface font_port_arbiter_if #(
    parameter int CHAR_BITS = 7,
    parameter int ROW_BITS  = 4,
    parameter int ADDR_W    = CHAR_BITS + ROW_BITS,
    parameter int DATA_W    = 8
);
    // display renderer side
    logic                 disp_req;
    logic [CHAR_BITS-1:0] disp_char;
    logic [ROW_BITS-1:0]  disp_row;
    logic                 disp_valid;
    logic [DATA_W-1:0]    disp_data;
    logic                 disp_miss;

    // host loader / debug side
    logic                 host_valid;
    logic                 host_we;
    logic [ADDR_W-1:0]    host_addr;
    logic [DATA_W-1:0]    host_wdata;
    logic                 host_ready;
    logic                 host_rvalid;
    logic [DATA_W-1:0]    host_rdata;

    // font ROM side
    logic [ADDR_W-1:0]    rom_addr;
    logic                 rom_we;
    logic [DATA_W-1:0]    rom_din;
    logic [DATA_W-1:0]    rom_dout;

    // arbiter view
    modport slave (
        input  disp_req, disp_char, disp_row,
        input  host_valid, host_we, host_addr, host_wdata,
        input  rom_dout,
        output disp_valid, disp_data, disp_miss,
        output host_ready, host_rvalid, host_rdata,
        output rom_addr, rom_we, rom_din
    );

    // requesters and ROM view
    modport master (
        output disp_req, disp_char, disp_row,
        output host_valid, host_we, host_addr, host_wdata,
        output rom_dout,
        input  disp_valid, disp_data, disp_miss,
        input  host_ready, host_rvalid, host_rdata,
        input  rom_addr, rom_we, rom_din
    );
endinterface

// File: rtl/font_port_arbiter.sv
// rtl/font_port_arbiter.sv - display-priority arbiter for the single-port font ROM with host starvation guard
module font_port_arbiter #(
    parameter int CHAR_BITS = 7,
    parameter int ROW_BITS  = 4,
    parameter int ADDR_W    = CHAR_BITS + ROW_BITS,
    parameter int DATA_W    = 8,
    parameter int MAX_WAIT  = 15
) (
    input logic                clk,
    input logic                rst,
    font_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {GNT_IDLE, GNT_DISP, GNT_HOST} grant_e;
    typedef enum logic [1:0] {TAG_NONE, TAG_DISP, TAG_HRD} tag_e;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    grant_e            grant;
    logic              forced;
    logic              disp_valid;
    logic              host_rvalid;

    logic [7:0]        wait_cnt_q,    wait_cnt_d;
    logic [ADDR_W-1:0] rom_addr_q,    rom_addr_d;
    logic              rom_we_q,      rom_we_d;
    logic [DATA_W-1:0] rom_din_q,     rom_din_d;
    tag_e              tag_b_q,       tag_b_d;
    tag_e              tag_c_q,       tag_c_d;
    logic              miss_b_q,      miss_b_d;
    logic              miss_c_q,      miss_c_d;
    logic [DATA_W-1:0] disp_data_q,   disp_data_d;
    logic [DATA_W-1:0] host_rdata_q,  host_rdata_d;

    // Stage A grant: host wins when forced by starvation or when the display is quiet
    always_comb begin
        forced = bus.host_valid && (wait_cnt_q == MAX_WAIT_C);
        grant  = GNT_IDLE;
        if (rst) begin
            grant = GNT_IDLE;
        end else if (forced || (bus.host_valid && !bus.disp_req)) begin
            grant = GNT_HOST;
        end else if (bus.disp_req) begin
            grant = GNT_DISP;
        end
    end

    // Next state: starvation counter, ROM request register and return-steering tags
    always_comb begin
        wait_cnt_d   = wait_cnt_q;
        rom_addr_d   = rom_addr_q;
        rom_din_d    = rom_din_q;
        rom_we_d     = 1'b0;
        tag_b_d      = TAG_NONE;
        miss_b_d     = bus.disp_req && (grant == GNT_HOST);
        tag_c_d      = tag_b_q;
        miss_c_d     = miss_b_q;

        if (!bus.host_valid || (grant == GNT_HOST)) begin
            wait_cnt_d = 8'd0;
        end else if (wait_cnt_q != MAX_WAIT_C) begin
            wait_cnt_d = wait_cnt_q + 8'd1;
        end

        case (grant)
            GNT_DISP: begin
                rom_addr_d = {bus.disp_char, bus.disp_row};
                tag_b_d    = TAG_DISP;
            end
            GNT_HOST: begin
                rom_addr_d = bus.host_addr;
                if (bus.host_we) begin
                    rom_we_d  = 1'b1;
                    rom_din_d = bus.host_wdata;
                end else begin
                    tag_b_d = TAG_HRD;
                end
            end
            default: ;
        endcase

        // Return data arrives in stage C; gated by rst so no pulse escapes a reset cycle
        disp_valid   = !rst && (tag_c_q == TAG_DISP);
        host_rvalid  = !rst && (tag_c_q == TAG_HRD);
        disp_data_d  = disp_valid  ? bus.rom_dout : disp_data_q;
        host_rdata_d = host_rvalid ? bus.rom_dout : host_rdata_q;
    end

    // Pipeline and hold registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q   <= 8'd0;
            rom_addr_q   <= '0;
            rom_we_q     <= 1'b0;
            rom_din_q    <= '0;
            tag_b_q      <= TAG_NONE;
            tag_c_q      <= TAG_NONE;
            miss_b_q     <= 1'b0;
            miss_c_q     <= 1'b0;
            disp_data_q  <= '0;
            host_rdata_q <= '0;
        end else begin
            wait_cnt_q   <= wait_cnt_d;
            rom_addr_q   <= rom_addr_d;
            rom_we_q     <= rom_we_d;
            rom_din_q    <= rom_din_d;
            tag_b_q      <= tag_b_d;
            tag_c_q      <= tag_c_d;
            miss_b_q     <= miss_b_d;
            miss_c_q     <= miss_c_d;
            disp_data_q  <= disp_data_d;
            host_rdata_q <= host_rdata_d;
        end
    end

    assign bus.host_ready  = bus.host_valid && (grant == GNT_HOST);
    assign bus.disp_valid  = disp_valid;
    assign bus.disp_data   = disp_valid ? bus.rom_dout : disp_data_q;
    assign bus.disp_miss   = !rst && miss_c_q;
    assign bus.host_rvalid = host_rvalid;
    assign bus.host_rdata  = host_rvalid ? bus.rom_dout : host_rdata_q;
    assign bus.rom_addr    = rom_addr_q;
    // A write already registered but not yet committed is dropped if reset arrives
    assign bus.rom_we      = rom_we_q && !rst;
    assign bus.rom_din     = rom_din_q;

endmodule

// File: tb/tb_font_port_arbiter.sv
// tb/tb_font_port_arbiter.sv - directed self-checking bench for font_port_arbiter
module tb_font_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rom_clr = 1'b1;
    int   checks = 0;
    int   errors = 0;

    font_port_arbiter_if #(.CHAR_BITS(7), .ROW_BITS(4), .DATA_W(8)) bus ();

    font_port_arbiter #(
        .CHAR_BITS(7), .ROW_BITS(4), .DATA_W(8), .MAX_WAIT(15)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Font ROM model: preset contents are a fixed function of address, writes overlay them
    function automatic logic [7:0] rom_init(input logic [10:0] a);
        return 8'((32'(a) * 7 + 3) & 32'hFF);
    endfunction

    logic [7:0] mem     [0:2047];
    logic       written [0:2047];

    always @(posedge clk) begin
        if (rom_clr) begin
            for (int k = 0; k < 2048; k++) written[k] <= 1'b0;
        end else if (bus.rom_we) begin
            mem[bus.rom_addr]     <= bus.rom_din;
            written[bus.rom_addr] <= 1'b1;
        end
        bus.rom_dout <= (!rom_clr && written[bus.rom_addr]) ? mem[bus.rom_addr] : rom_init(bus.rom_addr);
    end

    task automatic chk_core(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        chk_core(tag, 32'(obs), 32'(exp));
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        chk_core(tag, 32'(obs), 32'(exp));
    endtask

    task automatic chk11(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        chk_core(tag, 32'(obs), 32'(exp));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.disp_req   = 1'b0;
        bus.disp_char  = '0;
        bus.disp_row   = '0;
        bus.host_valid = 1'b0;
        bus.host_we    = 1'b0;
        bus.host_addr  = '0;
        bus.host_wdata = '0;
    endtask

    task automatic check_all_zero(input string tag);
        chk1({tag, "_disp_valid"},  bus.disp_valid,  1'b0);
        chk8({tag, "_disp_data"},   bus.disp_data,   8'h00);
        chk1({tag, "_disp_miss"},   bus.disp_miss,   1'b0);
        chk1({tag, "_host_ready"},  bus.host_ready,  1'b0);
        chk1({tag, "_host_rvalid"}, bus.host_rvalid, 1'b0);
        chk8({tag, "_host_rdata"},  bus.host_rdata,  8'h00);
        chk11({tag, "_rom_addr"},   bus.rom_addr,    11'h000);
        chk1({tag, "_rom_we"},      bus.rom_we,      1'b0);
        chk8({tag, "_rom_din"},     bus.rom_din,     8'h00);
    endtask

    initial begin
        clear_inputs();
        cyc();
        rom_clr = 1'b0;
        cyc();
        // host_ready must stay low while reset is held
        bus.host_valid = 1'b1;
        #1;
        chk1("rst_host_ready", bus.host_ready, 1'b0);
        bus.host_valid = 1'b0;
        cyc();
        rst = 1'b0;
        #1;
        check_all_zero("reset");

        // Display single fetch: char 0x41 row 3
        bus.disp_req = 1'b1; bus.disp_char = 7'h41; bus.disp_row = 4'h3;
        cyc();
        bus.disp_req = 1'b0;
        chk11("disp_rom_addr", bus.rom_addr, 11'h413);
        chk1("disp_rom_we", bus.rom_we, 1'b0);
        cyc();
        chk1("disp_valid", bus.disp_valid, 1'b1);
        chk8("disp_data", bus.disp_data, 8'h88);
        cyc();
        chk1("disp_valid_end", bus.disp_valid, 1'b0);
        chk8("disp_data_hold", bus.disp_data, 8'h88);

        // Display back-to-back, one per cycle
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                bus.disp_req = 1'b1; bus.disp_char = 7'(8'h10 + i); bus.disp_row = 4'(i);
            end else begin
                bus.disp_req = 1'b0;
            end
            if (i >= 2) begin
                chk1("b2b_valid", bus.disp_valid, 1'b1);
                chk8("b2b_data", bus.disp_data, rom_init({7'(8'h10 + i - 2), 4'(i - 2)}));
            end
            cyc();
        end
        chk1("b2b_valid_end", bus.disp_valid, 1'b0);

        // Host write 0x5A5 <= 0xC3, then read it back the next cycle
        bus.host_valid = 1'b1; bus.host_we = 1'b1; bus.host_addr = 11'h5A5; bus.host_wdata = 8'hC3;
        #1;
        chk1("hw_ready", bus.host_ready, 1'b1);
        cyc();
        chk1("hw_rom_we", bus.rom_we, 1'b1);
        chk11("hw_rom_addr", bus.rom_addr, 11'h5A5);
        chk8("hw_rom_din", bus.rom_din, 8'hC3);
        bus.host_we = 1'b0; bus.host_wdata = 8'h00;
        #1;
        chk1("hr_ready", bus.host_ready, 1'b1);
        cyc();
        bus.host_valid = 1'b0;
        chk1("hw_we_one_cycle", bus.rom_we, 1'b0);
        chk1("hr_rvalid_early", bus.host_rvalid, 1'b0);
        cyc();
        chk1("hr_rvalid", bus.host_rvalid, 1'b1);
        chk8("hr_rdata", bus.host_rdata, 8'hC3);
        cyc();
        chk1("hr_rvalid_end", bus.host_rvalid, 1'b0);
        chk8("hr_rdata_hold", bus.host_rdata, 8'hC3);

        // Continuous contention: host read of 0x123 forced through on the 16th cycle
        for (int c = 0; c < 22; c++) begin
            bus.disp_req   = (c < 20);
            bus.disp_char  = 7'(c);
            bus.disp_row   = 4'h0;
            bus.host_valid = (c <= 15);
            bus.host_we    = 1'b0;
            bus.host_addr  = 11'h123;
            #1;
            chk1("cont_ready", bus.host_ready, c == 15);
            if (c >= 2) begin
                chk1("cont_disp_valid", bus.disp_valid, (c - 2 != 15) && (c - 2 < 20));
                chk1("cont_disp_miss", bus.disp_miss, c == 17);
                chk1("cont_host_rvalid", bus.host_rvalid, c == 17);
                if ((c - 2 != 15) && (c - 2 < 20))
                    chk8("cont_disp_data", bus.disp_data, rom_init({7'(c - 2), 4'h0}));
            end
            cyc();
        end
        chk8("cont_host_rdata", bus.host_rdata, 8'hF8);
        clear_inputs();

        // Idle gap in display traffic lets a pending host write through without a miss
        for (int c = 0; c < 8; c++) begin
            bus.disp_req   = (c < 6) && (c != 3);
            bus.disp_char  = 7'(8'h20 + c);
            bus.host_valid = (c <= 3);
            bus.host_we    = 1'b1;
            bus.host_addr  = 11'h0AA;
            bus.host_wdata = 8'h77;
            #1;
            chk1("gap_ready", bus.host_ready, c == 3);
            if (c >= 2) begin
                chk1("gap_disp_miss", bus.disp_miss, 1'b0);
                chk1("gap_disp_valid", bus.disp_valid, (c - 2 < 6) && (c - 2 != 3));
            end
            cyc();
        end
        clear_inputs();

        // Host abandons after 5 stalled cycles; display stream unaffected
        for (int c = 0; c < 10; c++) begin
            bus.disp_req   = (c < 8);
            bus.disp_char  = 7'(8'h30 + c);
            bus.host_valid = (c < 5);
            bus.host_addr  = 11'h200;
            #1;
            chk1("abn_ready", bus.host_ready, 1'b0);
            if (c >= 2) begin
                chk1("abn_disp_valid", bus.disp_valid, c - 2 < 8);
                chk1("abn_disp_miss", bus.disp_miss, 1'b0);
            end
            cyc();
        end
        // A fresh stall must again take the full 16 cycles, proving the counter cleared
        for (int c = 0; c < 18; c++) begin
            bus.disp_req   = (c < 16);
            bus.disp_char  = 7'(c);
            bus.host_valid = (c <= 15);
            bus.host_addr  = 11'h200;
            #1;
            chk1("abn2_ready", bus.host_ready, c == 15);
            if (c == 17) chk1("abn2_disp_miss", bus.disp_miss, 1'b1);
            cyc();
        end
        clear_inputs();
        cyc();
        cyc();

        // Reset after a display grant: no disp_valid afterwards
        bus.disp_req = 1'b1; bus.disp_char = 7'h05; bus.disp_row = 4'h1;
        cyc();
        bus.disp_req = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        check_all_zero("rst_disp");
        cyc();
        chk1("rst_disp_valid_late", bus.disp_valid, 1'b0);

        // Reset after a host read grant: no host_rvalid afterwards
        bus.host_valid = 1'b1; bus.host_we = 1'b0; bus.host_addr = 11'h300;
        #1;
        chk1("rst_hr_ready", bus.host_ready, 1'b1);
        cyc();
        bus.host_valid = 1'b0;
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        check_all_zero("rst_hr");
        cyc();
        chk1("rst_hr_rvalid_late", bus.host_rvalid, 1'b0);

        // Reset with a write registered but not committed: ROM keeps its old value
        bus.host_valid = 1'b1; bus.host_we = 1'b1; bus.host_addr = 11'h321; bus.host_wdata = 8'hEE;
        #1;
        chk1("rst_hw_ready", bus.host_ready, 1'b1);
        cyc();
        bus.host_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk1("rst_hw_rom_we", bus.rom_we, 1'b0);
        cyc();
        rst = 1'b0;
        bus.host_valid = 1'b1; bus.host_we = 1'b0; bus.host_addr = 11'h321;
        cyc();
        bus.host_addr = 11'h0AA;
        cyc();
        bus.host_valid = 1'b0;
        chk1("rb_old_rvalid", bus.host_rvalid, 1'b1);
        chk8("rb_old_rdata", bus.host_rdata, 8'hEA);
        cyc();
        chk1("rb_gap_rvalid", bus.host_rvalid, 1'b1);
        chk8("rb_gap_rdata", bus.host_rdata, 8'h77);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
